// File: rtl/seq_pkg.sv
// Shared encodings for the stage sequencer: FSM states, stage indices and enable masks.
// Contents: ST_* state codes, STG_* stage indices, EN_* per-state enable masks,
//           helpers en_mask(), is_run(), stage_of().
package seq_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN_MEM = 3'd1;
  localparam logic [2:0] ST_RUN_PE  = 3'd2;
  localparam logic [2:0] ST_RUN_3B3 = 3'd3;
  localparam logic [2:0] ST_RUN_2B2 = 3'd4;
  localparam logic [2:0] ST_DISP    = 3'd5;
  localparam logic [2:0] ST_ERR     = 3'd6;

  // Stage indices, also the bit positions in start_pulse and err_stage codes
  localparam logic [1:0] STG_MEM = 2'd0;
  localparam logic [1:0] STG_PE  = 2'd1;
  localparam logic [1:0] STG_3B3 = 2'd2;
  localparam logic [1:0] STG_2B2 = 2'd3;

  // Enable masks, bit order {disp, 2b2, 3b3, pe, mem}; enables accumulate per stage
  localparam logic [4:0] EN_IDLE    = 5'b00000;
  localparam logic [4:0] EN_RUN_MEM = 5'b00001;
  localparam logic [4:0] EN_RUN_PE  = 5'b00011;
  localparam logic [4:0] EN_RUN_3B3 = 5'b00111;
  localparam logic [4:0] EN_RUN_2B2 = 5'b01111;
  localparam logic [4:0] EN_DISP    = 5'b11111;
  localparam logic [4:0] EN_ERR     = 5'b00000;

  function automatic logic [4:0] en_mask(input logic [2:0] st);
    case (st)
      ST_RUN_MEM: return EN_RUN_MEM;
      ST_RUN_PE:  return EN_RUN_PE;
      ST_RUN_3B3: return EN_RUN_3B3;
      ST_RUN_2B2: return EN_RUN_2B2;
      ST_DISP:    return EN_DISP;
      ST_ERR:     return EN_ERR;
      default:    return EN_IDLE;
    endcase
  endfunction

  function automatic logic is_run(input logic [2:0] st);
    return (st >= ST_RUN_MEM) && (st <= ST_RUN_2B2);
  endfunction

  function automatic logic [1:0] stage_of(input logic [2:0] st);
    case (st)
      ST_RUN_PE:  return STG_PE;
      ST_RUN_3B3: return STG_3B3;
      ST_RUN_2B2: return STG_2B2;
      default:    return STG_MEM;
    endcase
  endfunction

endpackage

// File: rtl/stage_timer.sv
// Cycle counter for the stage sequencer with clear/enable and two compare flags.
// Ports: clk, rst (sync active-low), i_clr, i_en; o_settle_hit, o_timeout_hit.
// Clear together with enable restarts the count at 1; increment saturates at all-ones.
module stage_timer #(
  parameter int unsigned GAP     = 16,
  parameter int unsigned TIMEOUT = 200000,
  parameter int unsigned CW      = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_settle_hit,
  output logic o_timeout_hit
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = i_en ? CW'(1) : '0;
    end else if (i_en && (r_cnt != '1)) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // settle_hit looks at the value being loaded so the registered start pulse
  // lands exactly GAP edges after the enable (GAP=0 hits on the clearing edge).
  assign o_settle_hit  = (w_cnt_nxt == CW'(GAP));
  // timeout_hit looks at the current WAIT cycle number (1..TIMEOUT).
  assign o_timeout_hit = (r_cnt == CW'(TIMEOUT));

endmodule

// File: rtl/stage_sequencer.sv
// Handshake reset sequencer: enables mem, pe, 3b3, 2b2, disp in order, pulsing start and awaiting done per stage.
// Ports: clk, rst (sync active-low), go, abort, clr, done_*; en_*, start_pulse[3:0], busy, finished, err, err_stage.
// All outputs registered from next-state; per-stage timeout after the start pulse lands in ERR.
module stage_sequencer #(
  parameter int unsigned GAP     = 16,
  parameter int unsigned TIMEOUT = 200000,
  parameter int unsigned CW      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       abort,
  input  logic       clr,
  input  logic       done_mem,
  input  logic       done_pe,
  input  logic       done_3b3,
  input  logic       done_2b2,
  output logic       en_mem,
  output logic       en_pe,
  output logic       en_3b3,
  output logic       en_2b2,
  output logic       en_disp,
  output logic [3:0] start_pulse,
  output logic       busy,
  output logic       finished,
  output logic       err,
  output logic [1:0] err_stage
);
  import seq_pkg::*;

  logic [2:0] r_state;
  logic       r_wait;       // 0: SETTLE (includes the pulse cycle), 1: WAIT
  logic [1:0] r_err_stage;
  logic [4:0] r_en;
  logic [3:0] r_start;
  logic       r_busy;
  logic       r_fin;
  logic       r_err;

  logic [2:0] w_state_nxt;
  logic       w_wait_nxt;
  logic [1:0] w_err_stage_nxt;
  logic [3:0] w_start_nxt;
  logic       w_tmr_clr;
  logic       w_tmr_en;
  logic       w_settle_hit;
  logic       w_timeout_hit;
  logic [3:0] w_done;
  logic       w_done_cur;

  stage_timer #(.GAP(GAP), .TIMEOUT(TIMEOUT), .CW(CW)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_tmr_clr),
    .i_en         (w_tmr_en),
    .o_settle_hit (w_settle_hit),
    .o_timeout_hit(w_timeout_hit)
  );

  assign w_done     = {done_2b2, done_3b3, done_pe, done_mem};
  assign w_done_cur = w_done[stage_of(r_state)];

  always_comb begin
    w_state_nxt     = r_state;
    w_wait_nxt      = r_wait;
    w_err_stage_nxt = r_err_stage;
    w_tmr_clr       = 1'b0;
    w_tmr_en        = 1'b0;
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt     = ST_IDLE;
      w_wait_nxt      = 1'b0;
      w_err_stage_nxt = '0;
      w_tmr_clr       = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (go && !abort) begin
            w_state_nxt = ST_RUN_MEM;
            w_wait_nxt  = 1'b0;
            w_tmr_clr   = 1'b1;
          end
        end
        ST_RUN_MEM, ST_RUN_PE, ST_RUN_3B3, ST_RUN_2B2: begin
          if (!r_wait) begin
            w_tmr_en = 1'b1;
            // Pulse cycle just ended: WAIT begins with the count at 1.
            if (r_start != '0) begin
              w_wait_nxt = 1'b1;
              w_tmr_clr  = 1'b1;
            end
          end else if (w_done_cur) begin
            // Done wins over a coincident timeout.
            w_state_nxt = (r_state == ST_RUN_2B2) ? ST_DISP : r_state + 3'd1;
            w_wait_nxt  = 1'b0;
            w_tmr_clr   = 1'b1;
          end else if (w_timeout_hit) begin
            w_state_nxt     = ST_ERR;
            w_wait_nxt      = 1'b0;
            w_err_stage_nxt = stage_of(r_state);
            w_tmr_clr       = 1'b1;
          end else begin
            w_tmr_en = 1'b1;
          end
        end
        ST_DISP: begin
        end
        ST_ERR: begin
          if (clr) begin
            w_state_nxt     = ST_IDLE;
            w_err_stage_nxt = '0;
            w_tmr_clr       = 1'b1;
          end
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_wait_nxt      = 1'b0;
          w_err_stage_nxt = '0;
          w_tmr_clr       = 1'b1;
        end
      endcase
    end
  end

  // Settle count only reaches GAP once per stage, so the pulse is single-shot.
  always_comb begin
    w_start_nxt = '0;
    if (is_run(w_state_nxt) && !w_wait_nxt && w_settle_hit) begin
      w_start_nxt = 4'd1 << stage_of(w_state_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_wait      <= 1'b0;
      r_err_stage <= '0;
      r_en        <= '0;
      r_start     <= '0;
      r_busy      <= 1'b0;
      r_fin       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait      <= w_wait_nxt;
      r_err_stage <= w_err_stage_nxt;
      r_en        <= en_mask(w_state_nxt);
      r_start     <= w_start_nxt;
      r_busy      <= is_run(w_state_nxt);
      r_fin       <= (w_state_nxt == ST_DISP);
      r_err       <= (w_state_nxt == ST_ERR);
    end
  end

  assign en_mem      = r_en[0];
  assign en_pe       = r_en[1];
  assign en_3b3      = r_en[2];
  assign en_2b2      = r_en[3];
  assign en_disp     = r_en[4];
  assign start_pulse = r_start;
  assign busy        = r_busy;
  assign finished    = r_fin;
  assign err         = r_err;
  assign err_stage   = r_err_stage;

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;

  localparam int TMO   = 8;
  localparam int NEVER = 100000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       go = 1'b0, abort = 1'b0, clr = 1'b0;
  logic [3:0] done = 4'b0;

  always #5 clk = ~clk;

  // instance A: GAP=2, instance B: GAP=0; both share stimulus
  logic a_en_mem, a_en_pe, a_en_3b3, a_en_2b2, a_en_disp, a_busy, a_fin, a_err;
  logic [3:0] a_sp;
  logic [1:0] a_es;
  logic b_en_mem, b_en_pe, b_en_3b3, b_en_2b2, b_en_disp, b_busy, b_fin, b_err;
  logic [3:0] b_sp;
  logic [1:0] b_es;

  stage_sequencer #(.GAP(2), .TIMEOUT(TMO), .CW(8)) u_dut_a (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .clr(clr),
    .done_mem(done[0]), .done_pe(done[1]), .done_3b3(done[2]), .done_2b2(done[3]),
    .en_mem(a_en_mem), .en_pe(a_en_pe), .en_3b3(a_en_3b3), .en_2b2(a_en_2b2), .en_disp(a_en_disp),
    .start_pulse(a_sp), .busy(a_busy), .finished(a_fin), .err(a_err), .err_stage(a_es)
  );

  stage_sequencer #(.GAP(0), .TIMEOUT(TMO), .CW(8)) u_dut_b (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .clr(clr),
    .done_mem(done[0]), .done_pe(done[1]), .done_3b3(done[2]), .done_2b2(done[3]),
    .en_mem(b_en_mem), .en_pe(b_en_pe), .en_3b3(b_en_3b3), .en_2b2(b_en_2b2), .en_disp(b_en_disp),
    .start_pulse(b_sp), .busy(b_busy), .finished(b_fin), .err(b_err), .err_stage(b_es)
  );

  logic [4:0] obs_en [2];
  logic [3:0] obs_sp [2];
  logic [4:0] obs_st [2];
  assign obs_en[0] = {a_en_disp, a_en_2b2, a_en_3b3, a_en_pe, a_en_mem};
  assign obs_en[1] = {b_en_disp, b_en_2b2, b_en_3b3, b_en_pe, b_en_mem};
  assign obs_sp[0] = a_sp;
  assign obs_sp[1] = b_sp;
  assign obs_st[0] = {a_busy, a_fin, a_err, a_es};
  assign obs_st[1] = {b_busy, b_fin, b_err, b_es};

  // Reference model: mode 0 idle, 1 running a stage, 2 disp, 3 err.
  // t = edges since the current stage's enable rose; pulse at t==gap,
  // WAIT cycle k is t==gap+k.
  int m_mode [2];
  int m_stg  [2];
  int m_t    [2];
  int m_es   [2];
  int gap    [2];
  int dly    [4];   // responder: done given this many cycles after the start pulse

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input int i);
    if (!rst) begin
      m_mode[i] = 0;
      m_es[i]   = 0;
    end else begin
      case (m_mode[i])
        0: if (go && !abort) begin
             m_mode[i] = 1; m_stg[i] = 0; m_t[i] = 0;
           end
        1: begin
          if (abort) m_mode[i] = 0;
          else if (m_t[i] > gap[i] && done[m_stg[i]]) begin
            if (m_stg[i] == 3) m_mode[i] = 2;
            else begin m_stg[i]++; m_t[i] = 0; end
          end else if (m_t[i] - gap[i] == TMO) begin
            m_mode[i] = 3; m_es[i] = m_stg[i];
          end else m_t[i]++;
        end
        2: if (abort) m_mode[i] = 0;
        default: if (abort || clr) begin m_mode[i] = 0; m_es[i] = 0; end
      endcase
    end
  endfunction

  task automatic check_outputs(input int i);
    logic [4:0] e_en;
    logic [3:0] e_sp;
    logic [4:0] e_st;
    e_en = '0;
    if (m_mode[i] == 1)
      for (int k = 0; k < 4; k++) if (k <= m_stg[i]) e_en[k] = 1'b1;
    if (m_mode[i] == 2) e_en = 5'b11111;
    e_sp = (m_mode[i] == 1 && m_t[i] == gap[i]) ? 4'(1 << m_stg[i]) : 4'b0;
    e_st = {m_mode[i] == 1, m_mode[i] == 2, m_mode[i] == 3,
            (m_mode[i] == 3) ? 2'(m_es[i]) : 2'b00};
    chk($sformatf("enables[%0d]", i), 32'(obs_en[i]), 32'(e_en));
    chk($sformatf("start_pulse[%0d]", i), 32'(obs_sp[i]), 32'(e_sp));
    chk($sformatf("status[%0d]", i), 32'(obs_st[i]), 32'(e_st));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_outputs(0);
    check_outputs(1);
    @(negedge clk);
  endtask

  // Drive done for instance A's current stage per dly[], OR'd with extra bits.
  task automatic run(input int n, input logic [3:0] extra_prob_en);
    for (int c = 0; c < n; c++) begin
      done = '0;
      if (m_mode[0] == 1 && m_t[0] == gap[0] + dly[m_stg[0]]) done[m_stg[0]] = 1'b1;
      if (extra_prob_en != 0) done = done | (4'($urandom) & 4'($urandom) & 4'($urandom) & extra_prob_en);
      tick();
    end
    done = '0;
  endtask

  task automatic pulse_go();
    go = 1'b1; run(1, 4'b0); go = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1; run(1, 4'b0); abort = 1'b0;
  endtask

  task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
  endtask

  initial begin
    gap[0] = 2; gap[1] = 0;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_stg[i] = 0; m_t[i] = 0; m_es[i] = 0;
    end
    set_dly(3, 3, 3, 3);
    @(negedge clk);

    // reset state
    rst = 1'b0; run(2, 4'b0);
    rst = 1'b1; run(2, 4'b0);

    // nominal pass
    pulse_go(); run(40, 4'b0);
    chk("nominal_finished", 32'({a_fin, a_busy, obs_en[0]}), 32'b10_11111);
    do_abort();

    // timeout in pe
    set_dly(3, NEVER, 3, 3);
    pulse_go(); run(30, 4'b0);
    chk("pe_timeout", 32'({a_err, a_es, obs_en[0]}), 32'b1_01_00000);
    clr = 1'b1; run(1, 4'b0); clr = 1'b0; run(2, 4'b0);
    do_abort();

    // done in last WAIT cycle beats the timeout
    set_dly(3, 3, TMO, 3);
    pulse_go(); run(50, 4'b0);
    chk("boundary_done_finished", 32'({a_fin, a_err}), 32'b10);
    do_abort();

    // done only coincident with the pulse is ignored
    set_dly(3, 3, 0, 3);
    pulse_go(); run(40, 4'b0);
    chk("coincident_done_err", 32'({a_err, a_es}), 32'b1_10);
    clr = 1'b1; run(1, 4'b0); clr = 1'b0;
    do_abort();

    // abort during RUN_2B2 settle, then restart
    set_dly(3, 3, 3, 3);
    pulse_go();
    for (int k = 0; k < 100 && !(m_mode[0] == 1 && m_stg[0] == 3 && m_t[0] == 1); k++) run(1, 4'b0);
    chk("reach_2b2_settle", 32'(m_mode[0] == 1 && m_stg[0] == 3 && m_t[0] == 1), 32'd1);
    abort = 1'b1; run(1, 4'b0); abort = 1'b0;
    chk("abort_enables_low", 32'(obs_en[0]), 32'd0);
    run(20, 4'b0);
    pulse_go(); run(2, 4'b0);
    chk("restart_at_mem", 32'(obs_en[0]), 32'b00001);
    do_abort();

    // synchronous reset while in DISP, go held during reset
    pulse_go(); run(40, 4'b0);
    rst = 1'b0; go = 1'b1; run(1, 4'b0); rst = 1'b1; go = 1'b0;
    chk("reset_in_disp", 32'({obs_en[0], obs_sp[0], obs_st[0]}), 32'd0);
    run(5, 4'b0);

    // randomized traffic with spurious done on every stage
    for (int c = 0; c < 3000; c++) begin
      go    = ($urandom % 8) == 0;
      abort = ($urandom % 64) == 0;
      clr   = ($urandom % 4) == 0;
      rst   = ($urandom % 300) != 0;
      if (go) set_dly(int'($urandom % 10), int'($urandom % 10), int'($urandom % 10), int'($urandom % 10));
      run(1, 4'b1111);
    end
    go = 1'b0; abort = 1'b0; clr = 1'b0; rst = 1'b1;
    run(2, 4'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Handshake-driven replacement for the fixed-time reset sequencer.
- Releases the datapath stages in order: mem -> pe -> 3b3 -> 2b2 -> disp.
- For each stage: issues a one-cycle start pulse, waits for that stage's done pulse, and enforces a per-stage timeout.
- Sits at top level beside the datapath and drives each stage's active-high enable, which is the inverse of that stage's reset.

Parameters:
- GAP, 16: settle cycles from a stage's enable rising to its start pulse (0 allowed).
- TIMEOUT, 200000: maximum cycles to wait for done after the start pulse (>=1).
- CW, 32: width of the internal cycle counter; must hold max(GAP, TIMEOUT).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset: synchronous, active-low.
- go  in  1  start request; sampled only in IDLE.
- abort  in  1  return to IDLE from any state.
- clr  in  1  leave ERR; ignored elsewhere.
- done_mem, done_pe, done_3b3, done_2b2  in  1 each  stage completion pulses.
- en_mem, en_pe, en_3b3, en_2b2, en_disp  out  1 each  stage enables (active high).
- start_pulse  out  4  one-hot start pulse; bit0 mem, bit1 pe, bit2 3b3, bit3 2b2.
- busy  out  1  high in any RUN_* state.
- finished  out  1  high in DISP.
- err  out  1  high in ERR.
- err_stage  out  2  index of the stage that timed out; valid while err=1.

Behaviour:
- All outputs are registered.
- rst=0 sampled at a clk edge: state IDLE, counter 0, all outputs 0.
- States: IDLE, RUN_MEM, RUN_PE, RUN_3B3, RUN_2B2, DISP, ERR.
- Each RUN_x state has two phases: SETTLE, then WAIT.
- Enables are cumulative, with x ranging over mem, pe, 3b3, 2b2:
  - en_x is high in RUN_x and in every later RUN state.
  - All four of those enables are high in DISP.
  - en_disp is high only in DISP.
  - All enables are 0 in IDLE and ERR.
- IDLE -> RUN_MEM: go=1 at an edge. en_mem rises at that edge and the counter clears.
- SETTLE phase:
  - The counter increments each cycle.
  - start_pulse[i] is high for exactly the one cycle beginning GAP edges after en_x rose.
  - GAP=0 means the pulse coincides with the enable rising.
- WAIT phase:
  - Starts the cycle after the start pulse; the counter restarts at 1.
  - done_x is sampled only in WAIT. A done_x coincident with the start pulse is ignored.
  - done_x=1 in WAIT: at that edge, advance to the next RUN state (RUN_2B2 advances to DISP). The counter clears.
  - No done_x within TIMEOUT WAIT cycles: at the edge ending WAIT cycle TIMEOUT, go to ERR with err_stage=i.
  - done_x in WAIT cycle TIMEOUT beats the timeout.
- Done inputs of stages other than the current one are ignored at all times.
- DISP:
  - finished=1 and busy=0.
  - Held indefinitely; leaves only on abort.
- ERR:
  - err=1; err_stage holds its value.
  - clr=1 -> IDLE at the next edge; err and err_stage clear.
- abort=1 in any state other than IDLE -> IDLE at the next edge.
  - Takes priority over done, timeout and clr.
  - All enables drop in that same edge.
  - An in-flight start pulse is not re-issued later.
- go while not in IDLE is ignored.
- go and abort together in IDLE: stay in IDLE.
- Reset mid-operation (rst=0 in any state): IDLE next edge; outputs as for reset.
- Counter: saturating compare; never wraps within a legal parameter set.

Decomposition:
- Shared package seq_pkg holds:
  - the state encoding localparams;
  - stage index constants (STG_MEM=0, STG_PE=1, STG_3B3=2, STG_2B2=3);
  - the enable-mask-per-state constants.
- One sub-module, stage_timer:
  - CW-bit counter with clear/enable;
  - flags settle_hit (count==GAP) and timeout_hit (count==TIMEOUT).
- The top FSM in stage_sequencer instantiates stage_timer once.

Test Plan:
1. Nominal pass (GAP=2, TIMEOUT=8):
   - go at cycle 0; each done_x given 3 cycles after its start pulse.
   - Expected: start_pulse sequence 0001, 0010, 0100, 1000; each pulse 2 cycles after its enable.
   - Expected: enables accumulate; finished=1 with all en high.
2. Timeout in pe:
   - done_pe never asserted.
   - Expected: ERR exactly 8 cycles after start_pulse[1]; err_stage=1; all enables 0.
   - Then clr=1 -> IDLE.
3. Boundary done:
   - done_3b3 in WAIT cycle 8 (TIMEOUT=8) -> advance to RUN_2B2, no err.
   - done_3b3 coincident with start_pulse[2] only -> timeout, err_stage=2.
4. Abort:
   - abort during RUN_2B2 SETTLE -> next edge IDLE; all enables 0; no start_pulse[3] ever.
   - A subsequent go restarts at mem.
5. Sync reset:
   - rst=0 for one cycle while in DISP -> IDLE and outputs 0 after that edge.
   - go during rst=0 -> no effect.
6. GAP=0:
   - start_pulse[0] in the same cycle en_mem first reads high.
   - Spurious done_pe during RUN_MEM -> ignored.
